uart_char_tx: RTL
=================

# uart_char_tx

Serial transmit stage that sits directly downstream of the board-to-text formatter. It pulls characters one at a time using the formatter's `print_nxt` / `char_out` / `done` handshake and shifts each one out as an 8N1 UART frame on `tx`. It paces requests so that exactly one character is requested per transmitted frame, and it stops requesting when the formatter raises `done`.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per serial bit (100 MHz / 115200). Must be ≥ 2.
- `START_HOLDOFF`, default 128: idle cycles after `done_in` falls before the first request. Must exceed the formatter's 100-cycle start-up delay.
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `char_in` in 8: character from the formatter (its `char_out`).
- `done_in` in 1: formatter `done`; 1 = no stream in progress.
- `print_nxt` out 1: one-cycle request for the next character (drives the formatter's `print_nxt`).
- `tx` out 1: serial line; idle high.
- `busy` out 1: high whenever the state is not IDLE.
- `sent_count` out 16: number of frames completed since reset; wraps 0xFFFF→0.

## Operation
- States: IDLE, HOLDOFF, REQ, FETCH, START, DATA, PARITY (present only with the macro), STOP.
- IDLE:
  - `tx`=1.
  - If `done_in`=0 is sampled → HOLDOFF, with the holdoff counter cleared.
- HOLDOFF:
  - Lasts exactly `START_HOLDOFF` cycles, then → REQ.
  - If `done_in`=1 is sampled at any point → IDLE.
- REQ: one cycle with `print_nxt`=1 → FETCH.
- FETCH:
  - One cycle. The formatter updates `char_in`/`done_in` on the edge that ends REQ.
  - On the edge that ends FETCH, the block samples both inputs.
  - If `done_in`=1: discard the sample → IDLE, with no frame and no count change. This is the formatter's terminating request.
  - Otherwise: latch `char_in` into the shift register → START.
- START: `tx`=0 for `CLKS_PER_BIT` cycles.
- DATA:
  - 8 bits, LSB first, each `CLKS_PER_BIT` cycles.
  - A 3-bit index tracks the current bit; after bit 7 → STOP, or → PARITY with the macro.
- STOP:
  - `tx`=1 for `CLKS_PER_BIT` cycles.
  - On the final cycle's edge, `sent_count` increments.
  - Then → REQ if `done_in`=0 (no holdoff between characters), else → IDLE.
- Baud counter:
  - Width `$clog2(CLKS_PER_BIT)`.
  - Cleared on every state entry; terminal count is `CLKS_PER_BIT-1`.
- `char_in` and `done_in` are ignored outside FETCH and the STOP exit decision.
- A `done_in` change mid-frame never truncates the frame in progress.

## Timing
- Reset values: `tx`=1, `print_nxt`=0, `busy`=0, `sent_count`=0, state IDLE.
- Asserting `rst_n` at any point, including mid-frame, forces `tx`=1 immediately, without waiting for a clock edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Request to start bit:
  - REQ cycle R, FETCH cycle R+1.
  - `tx` falls in cycle R+2.
- Frame lengths:
  - 10·`CLKS_PER_BIT` cycles without the macro.
  - 11·`CLKS_PER_BIT` cycles with the macro.
- Steady-state character period: frame length + 2 cycles (REQ + FETCH).
- `print_nxt` is never high for two consecutive cycles.
- `print_nxt` is never high while a frame is in flight.

## Configuration
- `UART_TX_PARITY_EN`:
  - Defined: a PARITY state is inserted after DATA. It drives the even-parity bit (XOR of the 8 data bits) for `CLKS_PER_BIT` cycles.
  - Undefined: the PARITY state and parity logic are absent; DATA → STOP, giving an 8N1 frame.

## Test plan
- Reset: hold `rst_n`=0 with `done_in`=0 → `tx`=1, `print_nxt`=0, `busy`=0, `sent_count`=0. No request is made until release.
- Single character, with `CLKS_PER_BIT`=4, `START_HOLDOFF`=8, no macro. `done_in` falls in cycle 0 and the model returns 0x41:
  - `print_nxt`=1 in cycle 9.
  - Start bit in cycles 11–14.
  - Data 1,0,0,0,0,0,1,0 in cycles 15–46.
  - Stop bit in cycles 47–50.
  - `sent_count`=1 and `print_nxt`=1 in cycle 51.
- Terminating request: the model raises `done_in` in response to a request → `tx` stays 1, `busy` falls after FETCH, `sent_count` unchanged, no further `print_nxt`.
- Mid-frame reset: pulse `rst_n` low during data bit 3 → `tx`=1 at once and all outputs at reset values. After release with `done_in`=0, the full `START_HOLDOFF` wait precedes the next `print_nxt`.
- Parity (macro defined, same settings as the single-character test):
  - 0x41 → parity bit 0 in cycles 47–50, stop bit in cycles 51–54.
  - 0x43 → parity bit 1.
- Full board, with the behavioural formatter connected and default `START_HOLDOFF`, after a formatter `start` pulse:
  - Exactly 580 frames, `sent_count`=0x0244.
  - First decoded bytes are 29×'-', then "\n\r".
  - Afterwards `busy`=0 and `tx`=1.

Source files
------------

// File: rtl/uart_char_tx.sv
// uart_char_tx: pulls characters from the board-to-text formatter with a
// print_nxt / char_in / done_in handshake and shifts each one out as a UART
// frame on tx. One request is made per frame. Requests stop once the
// formatter raises done_in.
//
// Optional feature macro: UART_TX_PARITY_EN. When it is defined, an
// even-parity bit is inserted between the data bits and the stop bit.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   char_in     character from the formatter
//   done_in     formatter done (1 = no stream in progress)
//   print_nxt   one-cycle request for the next character
//   tx          serial line, idle high
//   busy        high whenever the FSM is not idle
//   sent_count  frames completed since reset (wraps)
module uart_char_tx #(
    parameter int unsigned CLKS_PER_BIT  = 868,
    parameter int unsigned START_HOLDOFF = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  char_in,
    input  logic        done_in,
    output logic        print_nxt,
    output logic        tx,
    output logic        busy,
    output logic [15:0] sent_count
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned HOLD_W = $clog2(START_HOLDOFF + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(START_HOLDOFF - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLDOFF,
        S_REQ,
        S_FETCH,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [2:0]        idx_q, idx_d;
    logic [7:0]        data_q, data_d;
    logic [15:0]       count_d;
    logic              tx_d;
    logic              baud_end;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            hold_q     <= '0;
            idx_q      <= '0;
            data_q     <= '0;
            sent_count <= '0;
            tx         <= 1'b1;
            print_nxt  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            hold_q     <= hold_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            sent_count <= count_d;
            tx         <= tx_d;
            print_nxt  <= (state_d == S_REQ);
            busy       <= (state_d != S_IDLE);
        end
    end

    // Next-state and next-output logic; outputs are derived from the next
    // state so the registered outputs line up with the state they describe.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        data_d   = data_q;
        count_d  = sent_count;
        baud_end = (baud_q == BAUD_LAST);
        hold_d   = (state_q == S_HOLDOFF) ? hold_q + HOLD_W'(1) : '0;

        case (state_q)
            S_IDLE: begin
                if (!done_in) state_d = S_HOLDOFF;
            end
            S_HOLDOFF: begin
                if (done_in)                  state_d = S_IDLE;
                else if (hold_q == HOLD_LAST) state_d = S_REQ;
            end
            S_REQ: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                // done_in here answers the terminating request: no frame
                if (done_in) begin
                    state_d = S_IDLE;
                end else begin
                    data_d  = char_in;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_end) begin
                    idx_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_end) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (baud_end) begin
                    count_d = sent_count + 16'd1;
                    state_d = done_in ? S_IDLE : S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Baud counter restarts on every state entry and every bit boundary
        if (state_d != state_q || baud_end) baud_d = '0;
        else                                baud_d = baud_q + BAUD_W'(1);

        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = data_d[idx_d];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = ^data_q;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

endmodule
